// File: rtl/wb_arb_decode_pkg.sv
// Shared constants for the two-master / four-slave Wishbone arbiter-decoder.
// Slave-select codes, arbiter state encoding and the watchdog default live here.
package wb_arb_decode_pkg;

    localparam logic [1:0] SEL_MISC = 2'd0;
    localparam logic [1:0] SEL_V5C  = 2'd1;
    localparam logic [1:0] SEL_MMC  = 2'd2;
    localparam logic [1:0] SEL_SYS  = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/wb_arb_decode_rr_grant.sv
// Two-requester round-robin grant register with last-served pointer.
// The grant is held while the owner keeps cyc high; release returns to IDLE for one cycle.
module wb_rr_grant
    import wb_arb_decode_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_cyc,
    output logic [1:0] o_grant,
    output state_t     o_state
);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_grant, w_grant_nxt;
    logic       r_last, w_last_nxt;   // 0 = m0 served last, 1 = m1 served last

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (|i_req) begin
                    w_state_nxt = ST_OWNED;
                    if (i_req == 2'b11) w_grant_nxt = r_last ? 2'b01 : 2'b10;
                    else                w_grant_nxt = i_req;
                end
            end
            ST_OWNED: begin
                if (~|(r_grant & i_cyc)) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 2'b00;
                    w_last_nxt  = r_grant[1];
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    assign o_grant = r_grant;
    assign o_state = r_state;

endmodule

// File: rtl/wb_arb_decode.sv
// Two-master round-robin Wishbone arbiter with 4-way slave decode on adr[ADR_W-1:ADR_W-2].
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb_decode
    import wb_arb_decode_pkg::*;
#(
    parameter int ADR_W = 5,
    parameter int DAT_W = 8
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic [3:0]         s_cyc_o,
    output logic [3:0]         s_stb_o,
    output logic               s_we_o,
    output logic [ADR_W-3:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    input  logic [4*DAT_W-1:0] s_dat_i,
    input  logic [3:0]         s_ack_i,
    output logic [1:0]         grant_o
);

    logic [1:0]       w_req, w_cyc, w_grant;
    state_t           w_state;
    logic             w_owned, w_own_cyc, w_own_stb, w_own_we;
    logic [ADR_W-1:0] w_own_adr;
    logic [DAT_W-1:0] w_own_dat, w_rdat;
    logic [1:0]       w_sel;
    logic             w_sel_ack, w_fire;

    assign w_req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign w_cyc = {m1_cyc_i, m0_cyc_i};

    wb_rr_grant u_rr_grant (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_req   (w_req),
        .i_cyc   (w_cyc),
        .o_grant (w_grant),
        .o_state (w_state)
    );

    assign w_owned = (w_state == ST_OWNED);

    always_comb begin
        w_own_cyc = w_owned & m0_cyc_i;
        w_own_stb = m0_stb_i;
        w_own_we  = m0_we_i;
        w_own_adr = m0_adr_i;
        w_own_dat = m0_dat_i;
        if (w_grant[1]) begin
            w_own_cyc = w_owned & m1_cyc_i;
            w_own_stb = m1_stb_i;
            w_own_we  = m1_we_i;
            w_own_adr = m1_adr_i;
            w_own_dat = m1_dat_i;
        end
    end

    assign w_sel     = w_own_adr[ADR_W-1 -: 2];
    // Gating with owner cyc drops strobes and ignores late acks the cycle cyc falls.
    assign w_sel_ack = w_own_cyc & w_own_stb & s_ack_i[w_sel];
    assign w_rdat    = s_dat_i[w_sel*DAT_W +: DAT_W];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             w_stall;

    assign w_stall = w_own_cyc & w_own_stb & ~s_ack_i[w_sel];
    // Counter holds the number of earlier stalled cycles, so fire on the TIMEOUT-th one.
    assign w_fire  = w_stall & (r_to_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                r_to_cnt <= '0;
        else if (!w_stall || w_fire) r_to_cnt <= '0;
        else                         r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
`else
    assign w_fire = 1'b0;
`endif

    assign s_cyc_o = w_own_cyc ? sel_onehot(w_sel) : 4'b0000;
    assign s_stb_o = (w_own_cyc & w_own_stb & ~w_fire) ? sel_onehot(w_sel) : 4'b0000;
    assign s_we_o  = w_own_we;
    assign s_adr_o = w_own_adr[ADR_W-3:0];
    assign s_dat_o = w_own_dat;

    assign m0_ack_o = w_grant[0] & w_sel_ack & ~w_fire;
    assign m1_ack_o = w_grant[1] & w_sel_ack & ~w_fire;
    assign m0_err_o = w_grant[0] & w_fire;
    assign m1_err_o = w_grant[1] & w_fire;
    assign m0_dat_o = w_grant[0] ? w_rdat : '0;
    assign m1_dat_o = w_grant[1] ? w_rdat : '0;

    assign grant_o = w_grant;

endmodule

// File: doc/wb_arb_decode.md
Name: wb_arb_decode

Overview:
- Two-master, four-slave Wishbone arbiter and address decoder for the CPLD's 8-bit EPB-side register bus.
- Replaces the ad-hoc stb/adr[4:3] decode. It lets a second master (debug/serial engine) share the misc, v5c_sm, mmc_controller and system_block slaves with the EPB bridge.
- Arbitration is round-robin with cycle locking.
- An optional watchdog terminates stalled transfers.

Parameters:
- ADR_W, 5, master address width; slave select is adr[ADR_W-1:ADR_W-2].
- DAT_W, 8, data width.
- TIMEOUT, 255, cycles of unacknowledged stb before error (only with the optional feature).

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (EPB bridge) controls.
- m0_adr_i  in  ADR_W  master 0 address.
- m0_dat_i  in  DAT_W  master 0 write data.
- m0_dat_o  out  DAT_W  master 0 read data.
- m0_ack_o, m0_err_o  out  1 each  master 0 termination.
- m1_*  identical set for master 1.
- s_cyc_o, s_stb_o  out  4  per-slave strobes.
- s_we_o  out  1  shared write enable.
- s_adr_o  out  ADR_W-2  shared slave address.
- s_dat_o  out  DAT_W  shared write data.
- s_dat_i  in  4*DAT_W  packed slave read data; slave n at [n*DAT_W +: DAT_W].
- s_ack_i  in  4  per-slave acks.
- grant_o  out  2  one-hot current owner (bit0 = m0).

Behaviour:
- Reset (asynchronous, active-high) forces all of the following:
  - state IDLE, grant_o = 0, last-served pointer = m1 (so m0 wins first contention).
  - all s_cyc_o/s_stb_o and m*_ack_o/m*_err_o = 0; m*_dat_o = 0.
- Request definition: request_n = mn_cyc_i & mn_stb_i.
- State IDLE:
  - One requester: grant it on the next edge.
  - Both requesting: grant the master that is not the last-served one.
  - Move to OWNED.
- Request to slave latency: grant is registered, so slave stb rises exactly 1 cycle after the request is first seen in IDLE.
- State OWNED:
  - Owner signals are forwarded combinationally: s_stb_o[sel] = owner stb, s_cyc_o[sel] = owner cyc.
  - sel = owner adr[ADR_W-1:ADR_W-2]; other slave strobes are 0. s_adr_o, s_we_o and s_dat_o come from the owner.
  - owner ack_o = s_ack_i[sel] & owner stb, same cycle (combinational). owner dat_o = s_dat_i slice sel.
  - The non-owner sees ack/err = 0 and dat_o = 0.
- Lock: the grant is held while owner cyc_i = 1, so back-to-back strobes within one cycle stay with the owner.
- Release: owner cyc_i = 0 -> IDLE on the next edge, and the last-served pointer is set to that owner.
  - Re-arbitration in IDLE costs one cycle, so gaps between masters are at least 1 idle cycle.
- cyc dropped mid-transfer (no ack): slave strobes drop the same cycle; a later ack is ignored.
- Acks from non-selected slaves, or while stb = 0, are ignored.
- Simultaneous release and new request from the other master: release is taken first, then the grant goes to the other master on the following IDLE edge.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter increments each OWNED cycle with owner stb = 1 and selected ack = 0.
  - It clears on ack, on owner stb = 0, and in IDLE.
  - When count reaches TIMEOUT: owner err_o = 1 for exactly one cycle, ack_o = 0, s_stb_o forced to 0 that cycle, counter cleared.
  - The grant stays with the owner until its cyc drops.
- Undefined: no counter is present, m*_err_o tied 0, and a stalled transfer waits indefinitely.

Decomposition:
- Shared package/include holds:
  - slave-select constants SEL_MISC = 0, SEL_V5C = 1, SEL_MMC = 2, SEL_SYS = 3.
  - state encodings ST_IDLE / ST_OWNED.
  - the TIMEOUT default.
- One natural sub-module, wb_rr_grant: 2-requester round-robin grant register plus last-served pointer, with asynchronous reset. Decode and muxing stay in the parent.

Test Plan:
- Reset mid-transfer: m0 owns slave 1 with stb high; assert wb_rst_i asynchronously -> s_stb_o = 0, grant_o = 0 immediately. After release, m0 still wins contention.
- Single master read: m0 reads adr 5'h1A (slave 3), slave 3 acks 2 cycles later with 8'hA5 -> s_stb_o = 4'b1000 one cycle after request; m0_ack_o = 1 with m0_dat_o = 8'hA5 in the ack cycle.
- Contention: both masters request at the same edge from reset -> m0 granted first. m0 drops cyc after its ack -> 1 IDLE cycle, then grant_o = 2'b10. Repeat -> m0 is granted next (round-robin alternation).
- Lock: m1 performs 3 writes with cyc held high while m0 requests -> grant_o stays 2'b10 until m1 cyc falls. s_dat_o/s_adr_o track m1 each beat.
- Spurious/late ack: s_ack_i[2] pulses while slave 0 is selected, then m0 drops cyc and slave 0 acks late -> no m0_ack_o in either case.
- With WB_ARB_TIMEOUT_EN and TIMEOUT = 16: slave never acks -> m0_err_o pulses on the 16th stalled cycle with s_stb_o = 0 that cycle. Without the macro -> m0_err_o never asserts.
